// File: rtl/sc_match_scorer.sv
// Match scorer: buffers one pending match per lane, grades them lowest-lane-first,
// and keeps combo, multiplier and a saturating score for the HUD.
module sc_match_scorer #(
   parameter int          LANES       = 37,
   parameter int          SCORE_W     = 24,
   parameter logic [15:0] PERFECT_WIN = 16'd30,
   parameter logic [15:0] GOOD_WIN    = 16'd80
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pause,
   input  logic [LANES-1:0]      match_trigger,
   input  logic [LANES*16-1:0]   match_time,
   input  logic                  miss,
   output logic [SCORE_W-1:0]    score,
   output logic [9:0]            combo,
   output logic [9:0]            max_combo,
   output logic [2:0]            multiplier,
   output logic                  grade_valid,
   output logic [1:0]            grade,
   output logic [5:0]            grade_lane,
   output logic                  drop_flag
);

   localparam logic [9:0] COMBO_MAX = 10'd1023;

   function automatic logic [1:0] grade_of(input logic [15:0] err);
      if (err <= PERFECT_WIN) begin
         grade_of = 2'd2;
      end else if (err <= GOOD_WIN) begin
         grade_of = 2'd1;
      end else begin
         grade_of = 2'd0;
      end
   endfunction

   function automatic logic [2:0] mult_of(input logic [9:0] c);
      if (c >= 10'd30) begin
         mult_of = 3'd4;
      end else if (c >= 10'd20) begin
         mult_of = 3'd3;
      end else if (c >= 10'd10) begin
         mult_of = 3'd2;
      end else begin
         mult_of = 3'd1;
      end
   endfunction

   logic [LANES-1:0]   pending_r;
   logic [15:0]        err_r [LANES];
   logic [SCORE_W-1:0] score_r;
   logic [9:0]         combo_r;
   logic [9:0]         max_combo_r;
   logic [2:0]         mult_r;
   logic               grade_valid_r;
   logic [1:0]         grade_r;
   logic [5:0]         grade_lane_r;
   logic               drop_r;

   logic               svc_valid_s;
   logic [5:0]         svc_lane_s;
   logic [15:0]        svc_err_s;
   logic [1:0]         svc_grade_s;
   logic [5:0]         points_s;
   logic [SCORE_W:0]   score_sum_s;
   logic [SCORE_W-1:0] score_next_s;
   logic [9:0]         combo_inc_s;
   logic [9:0]         combo_next_s;
   logic [LANES-1:0]   clear_s;
   logic [LANES-1:0]   capture_s;
   logic               drop_s;

   // Lowest-index pending lane wins: scan downward so the last hit is the lowest.
   always_comb begin
      svc_valid_s = 1'b0;
      svc_lane_s  = 6'd0;
      svc_err_s   = 16'd0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (!pause && pending_r[i]) begin
            svc_valid_s = 1'b1;
            svc_lane_s  = 6'(i);
            svc_err_s   = err_r[i];
         end else begin
            svc_valid_s = svc_valid_s;
         end
      end
   end

   // Points, saturating score, combo update and lane slot bookkeeping.
   always_comb begin
      svc_grade_s  = grade_of(svc_err_s);
      points_s     = ({4'd0, svc_grade_s} + 6'd1) * {3'd0, mult_of(combo_r)};
      score_sum_s  = {1'b0, score_r} + (SCORE_W+1)'(points_s);
      if (score_sum_s[SCORE_W]) begin
         score_next_s = {SCORE_W{1'b1}};
      end else begin
         score_next_s = score_sum_s[SCORE_W-1:0];
      end
      if (combo_r == COMBO_MAX) begin
         combo_inc_s = COMBO_MAX;
      end else begin
         combo_inc_s = combo_r + 10'd1;
      end
      // A miss in the same cycle as a grade still ends the streak.
      if (!pause && miss) begin
         combo_next_s = 10'd0;
      end else if (svc_valid_s) begin
         combo_next_s = combo_inc_s;
      end else begin
         combo_next_s = combo_r;
      end
      if (svc_valid_s) begin
         clear_s = {{(LANES-1){1'b0}}, 1'b1} << svc_lane_s;
      end else begin
         clear_s = {LANES{1'b0}};
      end
      capture_s = match_trigger & (~pending_r | clear_s);
      drop_s    = |(match_trigger & pending_r & ~clear_s);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_r     <= {LANES{1'b0}};
         for (int i = 0; i < LANES; i++) begin
            err_r[i] <= 16'd0;
         end
         score_r       <= {SCORE_W{1'b0}};
         combo_r       <= 10'd0;
         max_combo_r   <= 10'd0;
         mult_r        <= 3'd1;
         grade_valid_r <= 1'b0;
         grade_r       <= 2'd0;
         grade_lane_r  <= 6'd0;
         drop_r        <= 1'b0;
      end else begin
         pending_r <= (pending_r & ~clear_s) | capture_s;
         for (int i = 0; i < LANES; i++) begin
            if (capture_s[i]) begin
               err_r[i] <= match_time[16*i +: 16];
            end
         end
         drop_r        <= drop_r | drop_s;
         grade_valid_r <= svc_valid_s;
         if (svc_valid_s) begin
            grade_r      <= svc_grade_s;
            grade_lane_r <= svc_lane_s;
            score_r      <= score_next_s;
            if (combo_inc_s > max_combo_r) begin
               max_combo_r <= combo_inc_s;
            end
         end
         combo_r <= combo_next_s;
         mult_r  <= mult_of(combo_next_s);
      end
   end

   assign score       = score_r;
   assign combo       = combo_r;
   assign max_combo   = max_combo_r;
   assign multiplier  = mult_r;
   assign grade_valid = grade_valid_r;
   assign grade       = grade_r;
   assign grade_lane  = grade_lane_r;
   assign drop_flag   = drop_r;

endmodule

// File: tb/tb_sc_match_scorer.sv
// Bench for sc_match_scorer: directed literal checks plus random traffic compared
// every cycle against a lane-array model; a second instance with an 8-bit score exercises saturation.
module tb_sc_match_scorer;

   localparam int LANES = 37;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 pause = 1'b0;
   logic [LANES-1:0]     trig = '0;
   logic [LANES*16-1:0]  mtime = '0;
   logic                 miss = 1'b0;

   logic [23:0] score;
   logic [7:0]  score8;
   logic [9:0]  combo, max_combo, combo8, max_combo8;
   logic [2:0]  multiplier, multiplier8;
   logic        grade_valid, grade_valid8, drop_flag, drop_flag8;
   logic [1:0]  grade, grade8;
   logic [5:0]  grade_lane, grade_lane8;

   sc_match_scorer u_dut (
      .clk(clk), .reset(reset), .pause(pause), .match_trigger(trig), .match_time(mtime),
      .miss(miss), .score(score), .combo(combo), .max_combo(max_combo),
      .multiplier(multiplier), .grade_valid(grade_valid), .grade(grade),
      .grade_lane(grade_lane), .drop_flag(drop_flag));

   sc_match_scorer #(.SCORE_W(8)) u_dut8 (
      .clk(clk), .reset(reset), .pause(pause), .match_trigger(trig), .match_time(mtime),
      .miss(miss), .score(score8), .combo(combo8), .max_combo(max_combo8),
      .multiplier(multiplier8), .grade_valid(grade_valid8), .grade(grade8),
      .grade_lane(grade_lane8), .drop_flag(drop_flag8));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: one pending slot per lane, plain integer score.
   bit       m_ready = 0;
   bit       pend [LANES];
   int       perr [LANES];
   longint   m_score;
   int       m_combo, m_max, m_grade, m_lane, k, g;
   bit       m_gv, m_drop;

   function automatic int mult_model(input int c);
      int q;
      q = c / 10;
      if (q > 3) q = 3;
      return 1 + q;
   endfunction

   // Inputs are stable on the falling edge and are the ones the next rising edge samples.
   always @(negedge clk) begin
      if (m_ready) begin
         chk("score",      score,       (m_score > 64'hFFFFFF) ? 32'hFFFFFF : 32'(m_score));
         chk("score8",     score8,      (m_score > 255) ? 32'd255 : 32'(m_score));
         chk("combo",      combo,       m_combo);
         chk("max_combo",  max_combo,   m_max);
         chk("multiplier", multiplier,  mult_model(m_combo));
         chk("grade_valid", grade_valid, m_gv);
         chk("drop_flag",  drop_flag,   m_drop);
         if (m_gv) begin
            chk("grade",      grade,      m_grade);
            chk("grade_lane", grade_lane, m_lane);
         end
      end
      if (reset) begin
         for (int i = 0; i < LANES; i++) pend[i] = 0;
         m_score = 0; m_combo = 0; m_max = 0; m_gv = 0; m_drop = 0;
         m_grade = 0; m_lane = 0; m_ready = 1;
      end else begin
         k = -1;
         m_gv = 0;
         if (!pause) begin
            for (int i = 0; i < LANES; i++) if (pend[i] && k < 0) k = i;
         end
         if (k >= 0) begin
            g = (perr[k] <= 30) ? 2 : (perr[k] <= 80) ? 1 : 0;
            m_score += (g + 1) * mult_model(m_combo);
            m_combo = (m_combo < 1023) ? m_combo + 1 : 1023;
            if (m_combo > m_max) m_max = m_combo;
            m_gv = 1; m_grade = g; m_lane = k; pend[k] = 0;
         end
         if (miss && !pause) m_combo = 0;
         for (int i = 0; i < LANES; i++) begin
            if (trig[i]) begin
               if (!pend[i]) begin
                  pend[i] = 1;
                  perr[i] = int'(mtime[16*i +: 16]);
               end else begin
                  m_drop = 1;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
      trig = '0; miss = 1'b0;
   endtask

   task automatic set_lane(input int lane, input int err);
      trig[lane] = 1'b1;
      mtime[16*lane +: 16] = 16'(err);
   endtask

   task automatic do_reset();
      reset = 1'b1; pause = 1'b0; trig = '0; miss = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      #1;
      do_reset();
      chk("rst_score", score, 0);
      chk("rst_mult", multiplier, 1);
      chk("rst_gv", grade_valid, 0);

      // Single PERFECT on lane 5, visible two cycles after the trigger.
      set_lane(5, 10); step();
      chk("t1_gv_early", grade_valid, 0);
      @(posedge clk); #1;
      chk("t1_gv", grade_valid, 1);
      chk("t1_grade", grade, 2);
      chk("t1_lane", grade_lane, 5);
      chk("t1_score", score, 3);
      chk("t1_combo", combo, 1);

      // Three lanes at once are serialised lowest-first.
      do_reset();
      set_lane(3, 50); set_lane(0, 200); set_lane(36, 5); step();
      @(posedge clk); #1;
      chk("t2_lane_a", grade_lane, 0); chk("t2_grade_a", grade, 0);
      @(posedge clk); #1;
      chk("t2_lane_b", grade_lane, 3); chk("t2_grade_b", grade, 1);
      @(posedge clk); #1;
      chk("t2_lane_c", grade_lane, 36); chk("t2_grade_c", grade, 2);
      chk("t2_score", score, 6);

      // Eleven PERFECTs: the 11th scores at multiplier 2, then a miss ends the streak.
      do_reset();
      for (int i = 0; i <= 10; i++) set_lane(i, 0);
      step();
      for (int i = 0; i < 10; i++) @(posedge clk);
      #1;
      chk("t3_mult10", multiplier, 2);
      chk("t3_score10", score, 30);
      @(posedge clk); #1;
      chk("t3_score", score, 36);
      miss = 1'b1; step();
      chk("t3_combo", combo, 0);
      chk("t3_mult", multiplier, 1);
      chk("t3_max", max_combo, 11);

      // Paused lane retriggered: second match dropped, first graded after unpause.
      do_reset();
      pause = 1'b1;
      set_lane(2, 100); step();
      step(); step();
      set_lane(2, 5); step();
      chk("t4_drop", drop_flag, 1);
      chk("t4_gv_paused", grade_valid, 0);
      pause = 1'b0;
      @(posedge clk); #1;
      chk("t4_gv", grade_valid, 1);
      chk("t4_grade", grade, 0);
      chk("t4_lane", grade_lane, 2);
      @(posedge clk); #1;
      chk("t4_single", grade_valid, 0);

      // Reset with four lanes pending discards them.
      do_reset();
      pause = 1'b1;
      set_lane(1, 1); set_lane(4, 2); set_lane(9, 3); set_lane(20, 4); step();
      do_reset();
      chk("t6_score", score, 0);
      chk("t6_drop", drop_flag, 0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("t6_no_grade", grade_valid, 0);
      end

      // Random traffic, checked by the model each cycle.
      for (int c = 0; c < 4000; c++) begin
         reset = ($urandom_range(0, 799) == 0);
         pause = ($urandom_range(0, 9) == 0);
         miss  = ($urandom_range(0, 39) == 0);
         for (int i = 0; i < LANES; i++) begin
            if ($urandom_range(0, 29) == 0) begin
               case ($urandom_range(0, 3))
                  0:       set_lane(i, $urandom_range(0, 35));
                  1:       set_lane(i, $urandom_range(74, 86));
                  2:       set_lane(i, $urandom_range(25, 35));
                  default: set_lane(i, $urandom_range(0, 65535));
               endcase
            end
         end
         step();
      end
      reset = 1'b0; pause = 1'b0;
      repeat (45) @(posedge clk);
      @(negedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
